// File: rtl/voting_pkg.sv
// Shared types and constants for the N-candidate voting machine.
package voting_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ARMED,
      ACK,
      RESULT
   } state_t;

   localparam logic MODE_VOTE   = 1'b0;
   localparam logic MODE_RESULT = 1'b1;

   // Index width for n items, never narrower than one bit.
   function automatic int unsigned idx_w(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/vote_debounce.sv
// Per-button debouncer: one qualify pulse after DEBOUNCE_CYC consecutive high samples.
module vote_debounce #(
   parameter int unsigned DEBOUNCE_CYC = 10
) (
   input  logic clk,
   input  logic reset,
   input  logic button,
   output logic qualify
);

   localparam int unsigned CW = $clog2(DEBOUNCE_CYC + 1);

   logic [CW-1:0] hold;

   // hold saturates at DEBOUNCE_CYC so a long press fires only once
   always_ff @(posedge clk) begin
      if (reset) begin
         hold    <= '0;
         qualify <= 1'b0;
      end else begin
         qualify <= 1'b0;
         if (!button) begin
            hold <= '0;
         end else if (hold != CW'(DEBOUNCE_CYC)) begin
            hold <= hold + 1'b1;
            if (hold == CW'(DEBOUNCE_CYC - 1))
               qualify <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/voting_machine_n.sv
// Armed-ballot voting machine with debounced buttons, saturating tallies and a
// registered winner/tie tracker.
module voting_machine_n
   import voting_pkg::*;
#(
   parameter int unsigned NUM_CAND     = 4,
   parameter int unsigned CNT_W        = 8,
   parameter int unsigned DEBOUNCE_CYC = 10,
   parameter int unsigned ACK_CYC      = 10
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          mode,
   input  logic                          arm,
   input  logic [NUM_CAND-1:0]           button,
   output logic [CNT_W-1:0]              led,
   output logic                          armed,
   output logic                          vote_ack,
   output logic                          vote_err,
   output logic [idx_w(NUM_CAND)-1:0]    winner,
   output logic                          tie,
   output logic [NUM_CAND-1:0]           sat
);

   localparam int unsigned WW = idx_w(NUM_CAND);
   localparam int unsigned AW = $clog2(ACK_CYC + 1);
   localparam logic [CNT_W-1:0] MAX = '1;

   state_t              state;
   logic [NUM_CAND-1:0] qual;
   logic [CNT_W-1:0]    tally [NUM_CAND];
   logic [AW-1:0]       ack_cnt;
   logic [WW-1:0]       sel;
   logic                multi;
   logic [CNT_W-1:0]    best;
   logic [WW-1:0]       best_idx;
   logic                dup;

   for (genvar g = 0; g < NUM_CAND; g++) begin : g_deb
      vote_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb (
         .clk     (clk),
         .reset   (reset),
         .button  (button[g]),
         .qualify (qual[g])
      );
   end

   always_comb begin
      sel = '0;
      for (int unsigned i = NUM_CAND; i > 0; i--)
         if (qual[i-1])
            sel = WW'(i - 1);
      multi = (qual & (qual - 1'b1)) != '0;
   end

   // Strict '>' keeps the lowest index on ties; dup flags any equal maximum.
   always_comb begin
      best     = tally[0];
      best_idx = '0;
      dup      = 1'b0;
      for (int unsigned i = 1; i < NUM_CAND; i++) begin
         if (tally[i] > best) begin
            best     = tally[i];
            best_idx = WW'(i);
            dup      = 1'b0;
         end else if (tally[i] == best) begin
            dup = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         winner <= '0;
         tie    <= 1'b1;
      end else begin
         winner <= best_idx;
         tie    <= dup;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         led      <= '0;
         armed    <= 1'b0;
         vote_ack <= 1'b0;
         vote_err <= 1'b0;
         sat      <= '0;
         ack_cnt  <= '0;
         for (int unsigned i = 0; i < NUM_CAND; i++)
            tally[i] <= '0;
      end else begin
         vote_ack <= 1'b0;
         vote_err <= 1'b0;
         if (mode == MODE_RESULT) begin
            // Entering RESULT from any state aborts ballots and ACK display.
            armed <= 1'b0;
            state <= RESULT;
            if (state != RESULT)
               led <= '0;
            else if (qual != '0)
               led <= tally[sel];
         end else begin
            case (state)
               IDLE: begin
                  led <= '0;
                  if (arm) begin
                     state <= ARMED;
                     armed <= 1'b1;
                  end
               end
               ARMED: begin
                  led <= '0;
                  if (multi) begin
                     vote_err <= 1'b1;
                  end else if (qual != '0) begin
                     if (tally[sel] != MAX)
                        tally[sel] <= tally[sel] + 1'b1;
                     if (tally[sel] >= MAX - 1'b1)
                        sat[sel] <= 1'b1;
                     vote_ack <= 1'b1;
                     armed    <= 1'b0;
                     led      <= '1;
                     ack_cnt  <= '0;
                     state    <= ACK;
                  end
               end
               ACK: begin
                  if (ack_cnt == AW'(ACK_CYC - 1)) begin
                     led   <= '0;
                     state <= IDLE;
                  end else begin
                     led     <= '1;
                     ack_cnt <= ack_cnt + 1'b1;
                  end
               end
               RESULT: begin
                  led   <= '0;
                  state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_voting_machine_n.sv
// Scoreboarded bench for voting_machine_n: a default instance and a CNT_W=4 instance.
module tb_voting_machine_n;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset, mode, arm;
   logic [3:0] button;
   logic [7:0] led;
   logic       armed, vote_ack, vote_err, tie;
   logic [1:0] winner;
   logic [3:0] sat;

   logic       reset4, mode4, arm4;
   logic [3:0] button4;
   logic [3:0] led4;
   logic       armed4, ack4, err4, tie4;
   logic [1:0] winner4;
   logic [3:0] sat4;

   int checks = 0;
   int errors = 0;
   logic [1:0] sb[$];
   logic [1:0] sb4[$];
   localparam logic [1:0] EV_ACK = 2'b01;
   localparam logic [1:0] EV_ERR = 2'b10;

   voting_machine_n dut (
      .clk(clk), .reset(reset), .mode(mode), .arm(arm), .button(button),
      .led(led), .armed(armed), .vote_ack(vote_ack), .vote_err(vote_err),
      .winner(winner), .tie(tie), .sat(sat)
   );

   voting_machine_n #(.CNT_W(4)) dut4 (
      .clk(clk), .reset(reset4), .mode(mode4), .arm(arm4), .button(button4),
      .led(led4), .armed(armed4), .vote_ack(ack4), .vote_err(err4),
      .winner(winner4), .tie(tie4), .sat(sat4)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Monitor: every ack/err pulse must match the next expected event.
   always @(negedge clk) begin
      if (vote_ack || vote_err) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event actual=%b required=none", {vote_err, vote_ack});
         end else begin
            chk("event", 32'({vote_err, vote_ack}), 32'(sb.pop_front()));
         end
      end
      if (ack4 || err4) begin
         if (sb4.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event4 actual=%b required=none", {err4, ack4});
         end else begin
            chk("event4", 32'({err4, ack4}), 32'(sb4.pop_front()));
         end
      end
   end

   task automatic nwait(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_arm(input bit d4);
      if (d4) arm4 = 1'b1; else arm = 1'b1;
      nwait(1);
      arm4 = 1'b0;
      arm  = 1'b0;
   endtask

   task automatic press(input bit d4, input int c, input int n);
      if (d4) button4[c] = 1'b1; else button[c] = 1'b1;
      nwait(n);
      button4 = '0;
      button  = '0;
   endtask

   task automatic vote(input bit d4, input int c, input bit do_arm);
      if (do_arm) pulse_arm(d4);
      if (d4) sb4.push_back(EV_ACK); else sb.push_back(EV_ACK);
      press(d4, c, 10);
      nwait(12);
   endtask

   initial begin
      reset = 1'b1; mode = 1'b0; arm = 1'b0; button = '0;
      reset4 = 1'b1; mode4 = 1'b0; arm4 = 1'b0; button4 = '0;
      nwait(3);
      reset = 1'b0;
      reset4 = 1'b0;
      nwait(1);
      chk("rst_led", 32'(led), 32'h0);
      chk("rst_armed", 32'(armed), 32'h0);
      chk("rst_winner", 32'(winner), 32'h0);
      chk("rst_tie", 32'(tie), 32'h1);
      chk("rst_sat", 32'(sat), 32'h0);

      // Single valid vote for candidate 2 and the ACK window
      pulse_arm(1'b0);
      chk("armed_set", 32'(armed), 32'h1);
      chk("armed_led", 32'(led), 32'h0);
      sb.push_back(EV_ACK);
      press(1'b0, 2, 10);
      nwait(1);
      for (int i = 0; i < 10; i++) begin
         chk("ack_led", 32'(led), 32'hFF);
         nwait(1);
      end
      chk("ack_end_led", 32'(led), 32'h0);
      chk("ack_end_armed", 32'(armed), 32'h0);
      nwait(1);
      chk("win_after_one", 32'(winner), 32'h2);
      chk("tie_after_one", 32'(tie), 32'h0);

      // Press without arm is ignored
      press(1'b0, 1, 10);
      nwait(3);
      chk("noarm_armed", 32'(armed), 32'h0);
      chk("noarm_led", 32'(led), 32'h0);

      // Simultaneous qualify on buttons 0 and 3 is rejected
      pulse_arm(1'b0);
      sb.push_back(EV_ERR);
      button = 4'b1001;
      nwait(10);
      button = '0;
      nwait(2);
      chk("err_armed", 32'(armed), 32'h1);
      vote(1'b0, 1, 1'b0);
      chk("err_vote_armed", 32'(armed), 32'h0);

      // Build tallies {3,5,5,1}
      for (int i = 0; i < 3; i++) vote(1'b0, 0, 1'b1);
      for (int i = 0; i < 4; i++) vote(1'b0, 1, 1'b1);
      for (int i = 0; i < 4; i++) vote(1'b0, 2, 1'b1);
      vote(1'b0, 3, 1'b1);
      chk("win_tie_idx", 32'(winner), 32'h1);
      chk("win_tie_flag", 32'(tie), 32'h1);

      // Result mode readouts
      mode = 1'b1;
      nwait(2);
      chk("res_entry_led", 32'(led), 32'h0);
      press(1'b0, 2, 10);
      nwait(1);
      chk("res_t2", 32'(led), 32'h5);
      press(1'b0, 0, 10);
      nwait(1);
      chk("res_t0", 32'(led), 32'h3);
      press(1'b0, 3, 10);
      nwait(1);
      chk("res_t3", 32'(led), 32'h1);
      nwait(5);
      chk("res_hold", 32'(led), 32'h1);
      button = 4'b0110;
      nwait(10);
      button = '0;
      nwait(1);
      chk("res_lowest", 32'(led), 32'h5);
      chk("res_winner", 32'(winner), 32'h1);

      // Reset during ACK
      mode = 1'b0;
      nwait(2);
      chk("res_exit_led", 32'(led), 32'h0);
      pulse_arm(1'b0);
      sb.push_back(EV_ACK);
      press(1'b0, 0, 10);
      nwait(2);
      chk("pre_rst_led", 32'(led), 32'hFF);
      reset = 1'b1;
      arm = 1'b1;
      nwait(1);
      reset = 1'b0;
      arm = 1'b0;
      chk("ackrst_led", 32'(led), 32'h0);
      chk("ackrst_armed", 32'(armed), 32'h0);
      chk("ackrst_sat", 32'(sat), 32'h0);
      nwait(2);
      chk("ackrst_winner", 32'(winner), 32'h0);
      chk("ackrst_tie", 32'(tie), 32'h1);
      pulse_arm(1'b0);
      chk("ackrst_idle_arm", 32'(armed), 32'h1);
      vote(1'b0, 3, 1'b0);
      nwait(1);
      chk("post_rst_winner", 32'(winner), 32'h3);
      chk("post_rst_tie", 32'(tie), 32'h0);

      // Saturation on the 4-bit instance
      for (int i = 0; i < 14; i++) vote(1'b1, 1, 1'b1);
      chk("sat_before", 32'(sat4), 32'h0);
      for (int i = 0; i < 3; i++) vote(1'b1, 1, 1'b1);
      chk("sat_after", 32'(sat4), 32'h2);
      chk("sat_winner", 32'(winner4), 32'h1);
      chk("sat_tie", 32'(tie4), 32'h0);
      mode4 = 1'b1;
      nwait(2);
      press(1'b1, 1, 10);
      nwait(1);
      chk("sat_tally", 32'(led4), 32'hF);

      nwait(3);
      chk("sb_empty", 32'(sb.size()), 32'h0);
      chk("sb4_empty", 32'(sb4.size()), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
